// File: rtl/pool_ppus.sv
// pool_ppus: array of P/2 post-processing units for the pooling path.
// Each lane: zero-point correction, requantize (x m1, rounding >>> n1),
// add output zero point, saturate to uint8. Four-stage pipeline with a
// parallel valid shift register and a 2-bit beat index counter.
// Optional macro POOL_PPUS_OUT_REG_EN adds one output register stage
// (latency 4 -> 5); results and beat ordering are unchanged.
module pool_ppus #(
  parameter int P = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [P/2*14-1:0]   ppus_Ys,
  input  logic                ppus_Ys_vld,
  input  logic [15:0]         ppus_neg_NXz,
  input  logic [7:0]          ppus_Yz,
  input  logic [25:0]         ppus_m1,
  input  logic [5:0]          ppus_n1,
  output logic [P/2*8-1:0]    res_Ys,
  output logic                res_Ys_vld,
  output logic [1:0]          res_beat_idx
);

  localparam int L   = P / 2;
  localparam int LAT = 4;

  // Per-beat parameters travel with the data so a change between beats
  // never affects beats already in the pipeline.
  logic [25:0]       m1_s1_reg;
  logic [5:0]        n1_s1_reg, n1_s2_reg;
  logic [7:0]        yz_s1_reg, yz_s2_reg, yz_s3_reg;

  logic [LAT-1:0]    vld_reg;
  logic [1:0]        idx_reg;

  logic signed [16:0] s1_reg [L];
  logic signed [43:0] p2_reg [L];
  logic signed [44:0] r3_reg [L];
  logic [7:0]         y4_reg [L];
  logic [L*8-1:0]     y4_flat;

  // Parameter carry registers; data-path only, no reset needed.
  always_ff @(posedge clk) begin
    m1_s1_reg <= ppus_m1;
    n1_s1_reg <= ppus_n1;
    yz_s1_reg <= ppus_Yz;
    n1_s2_reg <= n1_s1_reg;
    yz_s2_reg <= yz_s1_reg;
    yz_s3_reg <= yz_s2_reg;
  end

  // Valid shift register mirrors the data pipeline depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_reg <= '0;
    else       vld_reg <= {vld_reg[LAT-2:0], ppus_Ys_vld};
  end

  // Beat index advances once per emitted result beat, wrapping 3 -> 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 idx_reg <= 2'd0;
    else if (vld_reg[LAT-1])   idx_reg <= idx_reg + 2'd1;
  end

  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    logic [13:0]        ys_lane;
    logic signed [44:0] p_ext;
    logic signed [44:0] rnd;
    logic signed [44:0] r_next;
    logic signed [45:0] t_sum;
    logic [7:0]         y_next;

    assign ys_lane = ppus_Ys[gi*14 +: 14];

    // Stage 1: sign-extend the partial sum and add the negated zero-point sum.
    always_ff @(posedge clk) begin
      s1_reg[gi] <= $signed({{3{ys_lane[13]}}, ys_lane}) +
                    $signed({ppus_neg_NXz[15], ppus_neg_NXz});
    end

    // Stage 2: signed x unsigned multiply, full 44-bit product.
    always_ff @(posedge clk) begin
      p2_reg[gi] <= s1_reg[gi] * $signed({1'b0, m1_s1_reg});
    end

    // Stage 3 logic: rounding arithmetic shift. |p| < 2^42, so for n1 > 44
    // the exact rounded result is always 0; that case is clamped because the
    // rounding constant would not fit in 45 bits.
    always_comb begin
      p_ext  = {p2_reg[gi][43], p2_reg[gi]};
      rnd    = 45'sd1 <<< (n1_s2_reg - 6'd1);
      r_next = p_ext;
      if (n1_s2_reg != 6'd0) begin
        if (n1_s2_reg > 6'd44) r_next = '0;
        else                   r_next = (p_ext + rnd) >>> n1_s2_reg;
      end
    end

    // Stage 3 register.
    always_ff @(posedge clk) begin
      r3_reg[gi] <= r_next;
    end

    // Stage 4 logic: add output zero point and saturate to uint8.
    always_comb begin
      t_sum  = $signed({r3_reg[gi][44], r3_reg[gi]}) + $signed({38'd0, yz_s3_reg});
      y_next = t_sum[7:0];
      if (t_sum < 46'sd0)        y_next = 8'd0;
      else if (t_sum > 46'sd255) y_next = 8'd255;
    end

    // Stage 4 register; cleared on reset so outputs read 0 after reset.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) y4_reg[gi] <= 8'd0;
      else       y4_reg[gi] <= y_next;
    end

    assign y4_flat[gi*8 +: 8] = y4_reg[gi];
  end

`ifdef POOL_PPUS_OUT_REG_EN
  logic [L*8-1:0] out_ys_reg;
  logic           out_vld_reg;
  logic [1:0]     out_idx_reg;

  // Extra output register stage for timing-critical configurations.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_ys_reg  <= '0;
      out_vld_reg <= 1'b0;
      out_idx_reg <= 2'd0;
    end else begin
      out_ys_reg  <= y4_flat;
      out_vld_reg <= vld_reg[LAT-1];
      out_idx_reg <= idx_reg;
    end
  end

  assign res_Ys       = out_ys_reg;
  assign res_Ys_vld   = out_vld_reg;
  assign res_beat_idx = out_idx_reg;
`else
  assign res_Ys       = y4_flat;
  assign res_Ys_vld   = vld_reg[LAT-1];
  assign res_beat_idx = idx_reg;
`endif

endmodule
